path_sequencer: RTL
===================

# path_sequencer

Consumes the eight path words and the `path_found` flag produced by the CPU-side path capture stage. Snapshots a completed path and walks it hop by hop. Each hop (from-node, to-node) is issued to the downstream navigation/motion controller over a valid/ready handshake, and the next hop is held back until that controller reports arrival. Provides busy/done/error status so the top level knows when the bot has finished the route.

## Interface
Parameters:
- `NODE_W`, 5: node-ID width; a word is valid only if bits [31:NODE_W] are zero.
- `MAX_NODES`, 8: path slots; fixed to match `path0`..`path7`.
- `END_MARK`, 32'hFFFF_FFFF: terminator word; marks the first unused slot.

Ports:
- `clk` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `path0`..`path7` in 32 each: path words, slot 0 is the start node.
- `path_found` in 1: level flag from the capture stage; only its rising edge is used.
- `hop_valid` out 1: hop offer valid.
- `hop_from` out NODE_W: current node.
- `hop_to` out NODE_W: next node.
- `hop_idx` out 3: index of the hop being offered or travelled (0-based).
- `hop_ready` in 1: downstream accepts the hop.
- `arrived` in 1: one-cycle pulse; the bot has reached `hop_to`.
- `abort` in 1: synchronous cancel.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when the final hop arrives.
- `err` out 1: one-cycle pulse when a snapshot is rejected.
- `overrun` out 1: sticky; a `path_found` rising edge occurred while busy. Cleared only by reset or by the next accepted snapshot.

## Operation
- `path_found` is registered once (`pf_q`). Rise = `path_found & ~pf_q`.
- States: IDLE, LOAD, CHECK, EMIT, TRAVEL, DONE.
- IDLE → LOAD on rise. In LOAD, `path0`..`path7` are copied into `buf[0..7]`.
- LOAD → CHECK unconditionally.
- CHECK computes `len` = index of the first `END_MARK` (8 if there is none). The path is rejected if `len` < 2, or if any `buf[i]` with i < `len` has nonzero upper bits. Reject → `err` pulse, return to IDLE. Accept → `hop_idx` = 0, clear `overrun`, go to EMIT.
- EMIT: `hop_valid` = 1, `hop_from` = `buf[hop_idx][NODE_W-1:0]`, `hop_to` = `buf[hop_idx+1][NODE_W-1:0]`. These outputs stay stable until `hop_ready`. On `hop_valid & hop_ready` → TRAVEL.
- TRAVEL: `hop_valid` = 0. On `arrived`: if `hop_idx` == `len`-2 → DONE; otherwise increment `hop_idx` and go to EMIT.
- DONE: `done` = 1 for one cycle, then IDLE.
- `abort` in any non-IDLE state → IDLE next cycle; no `done`, no `err`.
- A rise while not in IDLE is ignored and sets `overrun`.
- `arrived` outside TRAVEL is ignored. `hop_ready` outside EMIT is ignored.

## Timing
- Reset values: state IDLE, `hop_valid` 0, `hop_from`/`hop_to` 0, `hop_idx` 0, `busy` 0, `done` 0, `err` 0, `overrun` 0, `pf_q` 0, `buf` all `END_MARK`.
- Latency: the edge `pf_q` sees the rise is cycle N. LOAD occurs at N+1, CHECK at N+2, and `hop_valid` is high from N+3.
- Handshake: transfer on the edge where `hop_valid & hop_ready`. `hop_ready` may be held high permanently; the minimum EMIT duration is 1 cycle.
- An `arrived` at cycle M in TRAVEL gives the next `hop_valid` at M+1, or `done` at M+1 after the last hop.
- Simultaneous events:
  - `abort` with `arrived` or `hop_ready`: `abort` wins.
  - Rise with DONE: `overrun` is set and the rise is not re-armed.
  - `abort` in the same cycle as a rise in IDLE: LOAD proceeds (abort only affects non-IDLE states).
- A full path (`len` = 8) gives 7 hops, with `hop_idx` reaching 6 and no wrap-around.
- Async reset mid-route returns to reset values immediately.
- All outputs are registered.

## Structure
- Shared package `path_pkg` holds `NODE_W`, `MAX_NODES`, `END_MARK`, the capture addresses 32'h0200_0008 / 32'h0200_000C, and the state enum.
- Sub-module `path_checker`, combinational: takes the 8 words and produces `len[3:0]` and `valid`. It is instantiated inside `path_sequencer` and used in CHECK.

## Test plan
- Path 3,7,12,END…: rise; `hop_ready` = 1; `arrived` 2 cycles after each accept. Expect hops (3→7, idx 0) and (7→12, idx 1), then a single `done` pulse; `hop_valid` first high at N+3.
- Full 8-node path 0..7, no `END_MARK`: expect 7 hops with `hop_idx` 0..6, then `done`.
- Bad paths: path 5,END → `err` pulse, no `hop_valid`. Path0 = 32'h0000_0025 with `len` 3 → `err`.
- Backpressure: hold `hop_ready` = 0 for 5 cycles in EMIT → `hop_from`/`hop_to` stable; extra `arrived` pulses during EMIT are ignored.
- `abort` in TRAVEL on hop 1 together with `arrived` → IDLE, `busy` 0, no `done`. A subsequent rise restarts at hop 0.
- Second rise during TRAVEL → `overrun` = 1, route unaffected; `overrun` clears on the next accepted snapshot. Async `reset` asserted mid-EMIT → all reset values.

Source files
------------

// File: rtl/path_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : path_pkg
//  Purpose  : Shared constants and state encoding for the path sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package path_pkg;

    localparam int          NODE_W    = 5;
    localparam int          MAX_NODES = 8;
    localparam logic [31:0] END_MARK  = 32'hFFFF_FFFF;

    // CPU-side capture register addresses (low and high halves of the path)
    localparam logic [31:0] PATH_ADDR_LO = 32'h0200_0008;
    localparam logic [31:0] PATH_ADDR_HI = 32'h0200_000C;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_CHECK  = 3'd2,
        S_EMIT   = 3'd3,
        S_TRAVEL = 3'd4,
        S_DONE   = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/path_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : path_sequencer_if
//  Purpose  : Hop offer / arrival handshake between the path sequencer
//             (master) and the navigation controller (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface path_sequencer_if #(
    parameter int NODE_W = path_pkg::NODE_W
);
    logic              hop_valid;
    logic [NODE_W-1:0] hop_from;
    logic [NODE_W-1:0] hop_to;
    logic [2:0]        hop_idx;
    logic              hop_ready;
    logic              arrived;

    modport master (
        output hop_valid, hop_from, hop_to, hop_idx,
        input  hop_ready, arrived
    );

    modport slave (
        input  hop_valid, hop_from, hop_to, hop_idx,
        output hop_ready, arrived
    );
endinterface
`default_nettype wire

// File: rtl/path_checker.sv
`default_nettype none
// ============================================================================
//  Module   : path_checker
//  Purpose  : Combinational path validation. Finds the first terminator
//             (length) and flags a path as valid when it has at least two
//             nodes and every node word before the terminator fits in NODE_W.
//  Revision : 1.0 - initial release
// ============================================================================
module path_checker #(
    parameter int          NODE_W    = path_pkg::NODE_W,
    parameter int          MAX_NODES = path_pkg::MAX_NODES,
    parameter logic [31:0] END_MARK  = path_pkg::END_MARK
) (
    input  wire [MAX_NODES-1:0][31:0] words,
    output logic [3:0]                len,
    output logic                      valid
);
    wire [MAX_NODES-1:0] is_end;
    wire [MAX_NODES-1:0] bad_upper;

    generate
        for (genvar i = 0; i < MAX_NODES; i++) begin : g_slot
            assign is_end[i]    = (words[i] == END_MARK);
            assign bad_upper[i] = |words[i][31:NODE_W];
        end
    endgenerate

    // Length is the lowest terminator index; then only slots below it are checked
    always_comb begin
        len = 4'(MAX_NODES);
        for (int i = MAX_NODES - 1; i >= 0; i--) begin
            if (is_end[i]) begin
                len = 4'(i);
            end
        end
        valid = (len >= 4'd2);
        for (int i = 0; i < MAX_NODES; i++) begin
            if ((4'(i) < len) && bad_upper[i]) begin
                valid = 1'b0;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/path_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : path_sequencer
//  Purpose  : Snapshots a captured path on the rising edge of path_found and
//             walks it hop by hop, offering each hop over a valid/ready
//             handshake and waiting for arrival before offering the next.
//  Revision : 1.0 - initial release
// ============================================================================
module path_sequencer #(
    parameter int          NODE_W    = path_pkg::NODE_W,
    parameter int          MAX_NODES = path_pkg::MAX_NODES,
    parameter logic [31:0] END_MARK  = path_pkg::END_MARK
) (
    input  wire                     clk,
    input  wire                     reset,
    input  wire [31:0]              path0,
    input  wire [31:0]              path1,
    input  wire [31:0]              path2,
    input  wire [31:0]              path3,
    input  wire [31:0]              path4,
    input  wire [31:0]              path5,
    input  wire [31:0]              path6,
    input  wire [31:0]              path7,
    input  wire                     path_found,
    input  wire                     abort,
    path_sequencer_if.master        hop_if,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    overrun
);
    import path_pkg::*;

    state_t                      state_q, state_d;
    logic                        pf_q;
    logic [MAX_NODES-1:0][31:0]  path_buf_q, path_buf_d;
    logic [3:0]                  len_q, len_d;
    logic [2:0]                  hop_idx_q, hop_idx_d;
    logic                        hop_valid_q, hop_valid_d;
    logic [NODE_W-1:0]           hop_from_q, hop_from_d;
    logic [NODE_W-1:0]           hop_to_q, hop_to_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        err_q, err_d;
    logic                        overrun_q, overrun_d;

    logic                        rise;
    logic [2:0]                  hop_nxt;
    logic [3:0]                  chk_len;
    logic                        chk_valid;
    wire  [MAX_NODES-1:0][31:0]  path_in;

    assign path_in = {path7, path6, path5, path4, path3, path2, path1, path0};

    path_checker #(
        .NODE_W    (NODE_W),
        .MAX_NODES (MAX_NODES),
        .END_MARK  (END_MARK)
    ) u_checker (
        .words (path_buf_q),
        .len   (chk_len),
        .valid (chk_valid)
    );

    // State register, snapshot buffer and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            pf_q        <= 1'b0;
            path_buf_q  <= {MAX_NODES{END_MARK}};
            len_q       <= 4'd0;
            hop_idx_q   <= 3'd0;
            hop_valid_q <= 1'b0;
            hop_from_q  <= '0;
            hop_to_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pf_q        <= path_found;
            path_buf_q  <= path_buf_d;
            len_q       <= len_d;
            hop_idx_q   <= hop_idx_d;
            hop_valid_q <= hop_valid_d;
            hop_from_q  <= hop_from_d;
            hop_to_q    <= hop_to_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Next-state logic; outputs are derived from the next state so they are registered
    always_comb begin
        state_d    = state_q;
        path_buf_d = path_buf_q;
        len_d      = len_q;
        hop_idx_d  = hop_idx_q;
        overrun_d  = overrun_q;
        err_d      = 1'b0;
        rise       = path_found & ~pf_q;

        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                path_buf_d = path_in;
                state_d    = S_CHECK;
            end
            S_CHECK: begin
                if (chk_valid) begin
                    len_d     = chk_len;
                    hop_idx_d = 3'd0;
                    overrun_d = 1'b0;
                    state_d   = S_EMIT;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_EMIT: begin
                // hop_valid is always high while in EMIT
                if (hop_if.hop_ready) begin
                    state_d = S_TRAVEL;
                end
            end
            S_TRAVEL: begin
                if (hop_if.arrived) begin
                    if ({1'b0, hop_idx_q} == (len_q - 4'd2)) begin
                        state_d = S_DONE;
                    end else begin
                        hop_idx_d = hop_idx_q + 3'd1;
                        state_d   = S_EMIT;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort dominates every other event outside IDLE and discards the snapshot result
        if (abort && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            len_d     = len_q;
            hop_idx_d = hop_idx_q;
            overrun_d = overrun_q;
            err_d     = 1'b0;
        end

        // A new path arriving while busy is dropped but remembered
        if (rise && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end

        hop_nxt     = hop_idx_d + 3'd1;
        hop_valid_d = (state_d == S_EMIT);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        hop_from_d  = hop_from_q;
        hop_to_d    = hop_to_q;
        if (state_d == S_EMIT) begin
            hop_from_d = path_buf_d[hop_idx_d][NODE_W-1:0];
            hop_to_d   = path_buf_d[hop_nxt][NODE_W-1:0];
        end
    end

    assign hop_if.hop_valid = hop_valid_q;
    assign hop_if.hop_from  = hop_from_q;
    assign hop_if.hop_to    = hop_to_q;
    assign hop_if.hop_idx   = hop_idx_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign err              = err_q;
    assign overrun          = overrun_q;

endmodule
`default_nettype wire
